maptables_ckpt: RTL and testbench

//  N-way rename map: speculative RAT (tag+ready per arch reg), retirement RRAT, and a ring of

---
 rtl/maptables_pkg.sv | 48 ++++
 rtl/map_ckpt_ring.sv | 97 +++++++++
 rtl/maptables_ckpt.sv | 121 ++++++++++++
 tb/tb_maptables_ckpt.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maptables_pkg.sv
// maptables_pkg: widths, map entry types and CDB wake-up helpers
// shared by the rename map and its checkpoint ring.
package maptables_pkg;

  localparam int ARCH_REGS   = 32;
  localparam int SCALAR      = 2;
  localparam int PRF_ENTRIES = 64;
  localparam int CKPT_DEPTH  = 4;

  localparam int AREG_W   = $clog2(ARCH_REGS);
  localparam int PTAG_W   = $clog2(PRF_ENTRIES);
  localparam int CKPT_W   = $clog2(CKPT_DEPTH);
  localparam int SLOT_W   = (SCALAR > 1) ? $clog2(SCALAR) : 1;
  localparam int RD_PORTS = 2 * SCALAR;

  typedef struct packed {
    logic [PTAG_W-1:0] tag;
    logic              ready;
  } map_entry_t;

  typedef map_entry_t [ARCH_REGS-1:0] map_table_t;

  function automatic logic cdb_hit(
    input logic [PTAG_W-1:0]             tag,
    input logic [SCALAR-1:0]             v,
    input logic [SCALAR-1:0][PTAG_W-1:0] t
  );
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < SCALAR; j++)
      hit = hit | (v[j] && (t[j] == tag));
    return hit;
  endfunction

  function automatic map_table_t cdb_wake(
    input map_table_t                    m,
    input logic [SCALAR-1:0]             v,
    input logic [SCALAR-1:0][PTAG_W-1:0] t
  );
    map_table_t r;
    r = m;
    for (int i = 0; i < ARCH_REGS; i++)
      if (cdb_hit(m[i].tag, v, t))
        r[i].ready = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/map_ckpt_ring.sv
// map_ckpt_ring: ring of RAT snapshots with head/tail/count,
// per-branch restore and CDB wake-up of stored entries.
module map_ckpt_ring
  import maptables_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            rollback,
  input  logic                            ckpt_take,
  input  map_table_t                      ckpt_snap,
  input  logic                            ckpt_restore,
  input  logic [CKPT_W-1:0]               ckpt_rs_id,
  input  logic                            ckpt_release,
  input  logic [SCALAR-1:0]               cdb_valid,
  input  logic [SCALAR-1:0][PTAG_W-1:0]   cdb_tag,
  output map_table_t                      rs_snap,
  output logic [CKPT_W-1:0]               tail_id,
  output logic                            full,
  output logic                            empty
);

  localparam int CNT_W = CKPT_W + 1;

  logic [CKPT_W-1:0] head, head_n;
  logic [CKPT_W-1:0] tail, tail_n;
  logic [CKPT_W-1:0] diff;
  logic [CKPT_W-1:0] rs_off;
  logic [CNT_W-1:0]  count, count_n;
  logic              do_take;
  logic              do_rel;
  map_table_t        ring [CKPT_DEPTH];

  assign full    = (count == CNT_W'(CKPT_DEPTH));
  assign empty   = (count == '0);
  assign tail_id = tail;
  assign rs_snap = ring[ckpt_rs_id];
  assign rs_off  = ckpt_rs_id - head;

  assign do_rel  = ckpt_release && !empty && !rollback;
  assign do_take = ckpt_take && !full && !rollback
                && !ckpt_restore;

  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    diff    = '0;
    if (rollback) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end else begin
      if (do_rel)
        head_n = head + 1'b1;
      if (ckpt_restore) begin
        tail_n = ckpt_rs_id + 1'b1;
        diff   = tail_n - head_n;
        // equal pointers on a live ring means it is still full
        if (diff != '0)
          count_n = CNT_W'(diff);
        else
          count_n = empty ? '0 : CNT_W'(CKPT_DEPTH);
      end else begin
        if (do_take)
          tail_n = tail + 1'b1;
        count_n = count + CNT_W'(do_take) - CNT_W'(do_rel);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < CKPT_DEPTH; i++)
      ring[i] <= cdb_wake(ring[i], cdb_valid, cdb_tag);
    if (do_take)
      ring[tail] <= ckpt_snap;
  end

  a_rs_live: assert property (
    @(posedge clock) disable iff (!reset)
    (ckpt_restore && !rollback) |->
      (CNT_W'(rs_off) < count)
      && !(ckpt_release && ckpt_rs_id == head)
  );

endmodule

// File: rtl/maptables_ckpt.sv
// maptables_ckpt: N-way rename map (RAT/RRAT) with branch checkpoints.
// Define MT_CDB_BYPASS_EN to let rd_ready see this cycle's CDB.
module maptables_ckpt
  import maptables_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic [RD_PORTS-1:0][AREG_W-1:0] rd_addr,
  output logic [RD_PORTS-1:0][PTAG_W-1:0] rd_tag,
  output logic [RD_PORTS-1:0]             rd_ready,
  input  logic [SCALAR-1:0]               wr_en,
  input  logic [SCALAR-1:0][AREG_W-1:0]   wr_addr,
  input  logic [SCALAR-1:0][PTAG_W-1:0]   wr_tag,
  input  logic [SCALAR-1:0]               cdb_valid,
  input  logic [SCALAR-1:0][PTAG_W-1:0]   cdb_tag,
  input  logic [SCALAR-1:0]               ret_en,
  input  logic [SCALAR-1:0][AREG_W-1:0]   ret_addr,
  input  logic [SCALAR-1:0][PTAG_W-1:0]   ret_tag,
  input  logic                            rollback,
  input  logic                            ckpt_take,
  input  logic [SLOT_W-1:0]               ckpt_slot,
  output logic [CKPT_W-1:0]               ckpt_id,
  input  logic                            ckpt_restore,
  input  logic [CKPT_W-1:0]               ckpt_rs_id,
  input  logic                            ckpt_release,
  output logic                            ckpt_full,
  output logic                            ckpt_empty
);

  map_table_t rat, rat_n, rat_cdb, rat_wr;
  map_table_t snap, rs_snap;
  logic [ARCH_REGS-1:0][PTAG_W-1:0] rrat, rrat_n;

  always_comb begin
    rrat_n = rrat;
    for (int j = 0; j < SCALAR; j++)
      if (ret_en[j] && ret_addr[j] != '0)
        rrat_n[ret_addr[j]] = ret_tag[j];
  end

  assign rat_cdb = cdb_wake(rat, cdb_valid, cdb_tag);

  // snapshot sees only the slots up to and including the branch
  always_comb begin
    rat_wr = rat_cdb;
    snap   = rat_cdb;
    for (int j = 0; j < SCALAR; j++)
      if (wr_en[j] && wr_addr[j] != '0) begin
        rat_wr[wr_addr[j]].tag   = wr_tag[j];
        rat_wr[wr_addr[j]].ready = 1'b0;
        if (SLOT_W'(j) <= ckpt_slot) begin
          snap[wr_addr[j]].tag   = wr_tag[j];
          snap[wr_addr[j]].ready = 1'b0;
        end
      end
  end

  always_comb begin
    rat_n = rat_wr;
    if (rollback) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_n[i].tag   = rrat_n[i];
        rat_n[i].ready = 1'b1;
      end
    end else if (ckpt_restore) begin
      rat_n = cdb_wake(rs_snap, cdb_valid, cdb_tag);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i].tag   <= PTAG_W'(i);
        rat[i].ready <= 1'b1;
        rrat[i]      <= PTAG_W'(i);
      end
    end else begin
      rat  <= rat_n;
      rrat <= rrat_n;
    end
  end

  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_tag[p]   = rat[rd_addr[p]].tag;
      rd_ready[p] = rat[rd_addr[p]].ready;
`ifdef MT_CDB_BYPASS_EN
      if (cdb_hit(rat[rd_addr[p]].tag, cdb_valid, cdb_tag))
        rd_ready[p] = 1'b1;
`endif
      for (int j = 0; j < SCALAR; j++)
        if (j < p / 2 && wr_en[j]
            && wr_addr[j] == rd_addr[p]) begin
          rd_tag[p]   = wr_tag[j];
          rd_ready[p] = 1'b0;
        end
      if (rd_addr[p] == '0) begin
        rd_tag[p]   = '0;
        rd_ready[p] = 1'b1;
      end
    end
  end

  map_ckpt_ring u_ring (
    .clock        (clock),
    .reset        (reset),
    .rollback     (rollback),
    .ckpt_take    (ckpt_take),
    .ckpt_snap    (snap),
    .ckpt_restore (ckpt_restore),
    .ckpt_rs_id   (ckpt_rs_id),
    .ckpt_release (ckpt_release),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .rs_snap      (rs_snap),
    .tail_id      (ckpt_id),
    .full         (ckpt_full),
    .empty        (ckpt_empty)
  );

endmodule

// File: tb/tb_maptables_ckpt.sv
// tb_maptables_ckpt: directed vectors for the rename map,
// checkpoint ring, rollback and asynchronous reset.
module tb_maptables_ckpt;
  import maptables_pkg::*;

`ifdef MT_CDB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [RD_PORTS-1:0][AREG_W-1:0] rd_addr;
  logic [RD_PORTS-1:0][PTAG_W-1:0] rd_tag;
  logic [RD_PORTS-1:0]             rd_ready;
  logic [SCALAR-1:0]               wr_en;
  logic [SCALAR-1:0][AREG_W-1:0]   wr_addr;
  logic [SCALAR-1:0][PTAG_W-1:0]   wr_tag;
  logic [SCALAR-1:0]               cdb_valid;
  logic [SCALAR-1:0][PTAG_W-1:0]   cdb_tag;
  logic [SCALAR-1:0]               ret_en;
  logic [SCALAR-1:0][AREG_W-1:0]   ret_addr;
  logic [SCALAR-1:0][PTAG_W-1:0]   ret_tag;
  logic                            rollback;
  logic                            ckpt_take;
  logic [SLOT_W-1:0]               ckpt_slot;
  logic [CKPT_W-1:0]               ckpt_id;
  logic                            ckpt_restore;
  logic [CKPT_W-1:0]               ckpt_rs_id;
  logic                            ckpt_release;
  logic                            ckpt_full;
  logic                            ckpt_empty;

  int n_chk = 0;
  int n_err = 0;

  maptables_ckpt dut (
    .clock        (clock),
    .reset        (reset),
    .rd_addr      (rd_addr),
    .rd_tag       (rd_tag),
    .rd_ready     (rd_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_tag       (wr_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .ret_en       (ret_en),
    .ret_addr     (ret_addr),
    .ret_tag      (ret_tag),
    .rollback     (rollback),
    .ckpt_take    (ckpt_take),
    .ckpt_slot    (ckpt_slot),
    .ckpt_id      (ckpt_id),
    .ckpt_restore (ckpt_restore),
    .ckpt_rs_id   (ckpt_rs_id),
    .ckpt_release (ckpt_release),
    .ckpt_full    (ckpt_full),
    .ckpt_empty   (ckpt_empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input int p,
                        input int t, input int r);
    check({tag, ".tag"}, int'(rd_tag[p]), t);
    check({tag, ".rdy"}, int'(rd_ready[p]), r);
  endtask

  task automatic idle();
    wr_en        = '0;
    wr_addr      = '0;
    wr_tag       = '0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    ret_en       = '0;
    ret_addr     = '0;
    ret_tag      = '0;
    rollback     = 1'b0;
    ckpt_take    = 1'b0;
    ckpt_slot    = '0;
    ckpt_restore = 1'b0;
    ckpt_rs_id   = '0;
    ckpt_release = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int s, input int a, input int t);
    wr_en[s]   = 1'b1;
    wr_addr[s] = AREG_W'(a);
    wr_tag[s]  = PTAG_W'(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rd_addr = '0;

    // 1: reset values
    #12;
    rd_addr[0] = 5;
    #1;
    chk_rd("rst_x5", 0, 5, 1);
    check("rst_empty", int'(ckpt_empty), 1);
    check("rst_full", int'(ckpt_full), 0);
    check("rst_id", int'(ckpt_id), 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk_rd("t1_x5", 0, 5, 1);

    // 2: in-bundle bypass, younger write wins
    wr(0, 3, 40);
    wr(1, 3, 41);
    rd_addr[0] = 3;
    rd_addr[2] = 3;
    #1;
    chk_rd("t2_byp", 2, 40, 0);
    chk_rd("t2_s0", 0, 3, 1);
    step();
    idle();
    #1;
    chk_rd("t2_rat", 0, 41, 0);

    // 3: CDB wake-up
    cdb_valid[0] = 1'b1;
    cdb_tag[0]   = 41;
    #1;
    chk_rd("t3_cdbcyc", 0, 41, BYP);
    step();
    idle();
    #1;
    chk_rd("t3_after", 0, 41, 1);

    // 4: fill ring with four snapshots
    wr(0, 7, 20);
    wr(1, 8, 21);
    ckpt_take = 1'b1;
    ckpt_slot = 0;
    #1;
    check("t4_id0", int'(ckpt_id), 0);
    step();
    idle();
    wr(0, 9, 22);
    wr(1, 7, 23);
    ckpt_take = 1'b1;
    ckpt_slot = 1;
    #1;
    check("t4_id1", int'(ckpt_id), 1);
    step();
    idle();
    wr(0, 10, 24);
    ckpt_take = 1'b1;
    #1;
    check("t4_id2", int'(ckpt_id), 2);
    step();
    idle();
    ckpt_take    = 1'b1;
    cdb_valid[1] = 1'b1;
    cdb_tag[1]   = 23;
    #1;
    check("t4_id3", int'(ckpt_id), 3);
    step();
    idle();
    #1;
    check("t4_full", int'(ckpt_full), 1);
    check("t4_nempty", int'(ckpt_empty), 0);
    ckpt_take = 1'b1;
    step();
    idle();
    #1;
    check("t4_take_full_id", int'(ckpt_id), 0);
    check("t4_take_full", int'(ckpt_full), 1);

    // restore id1 while writing, taking and broadcasting t22
    ckpt_restore = 1'b1;
    ckpt_rs_id   = 1;
    ckpt_take    = 1'b1;
    wr(0, 8, 60);
    cdb_valid[0] = 1'b1;
    cdb_tag[0]   = 22;
    step();
    idle();
    rd_addr[0] = 7;
    rd_addr[1] = 8;
    rd_addr[2] = 9;
    rd_addr[3] = 10;
    #1;
    chk_rd("t4_rs_x7", 0, 23, 1);
    chk_rd("t4_rs_x8", 1, 21, 0);
    chk_rd("t4_rs_x9", 2, 22, 1);
    chk_rd("t4_rs_x10", 3, 10, 1);
    check("t4_rs_tail", int'(ckpt_id), 2);
    check("t4_rs_full", int'(ckpt_full), 0);
    check("t4_rs_empty", int'(ckpt_empty), 0);

    // release leaves one live; three takes fill the ring
    ckpt_release = 1'b1;
    step();
    idle();
    ckpt_take = 1'b1;
    #1;
    check("t4_rel_id", int'(ckpt_id), 2);
    step();
    step();
    idle();
    #1;
    check("t4_cnt3", int'(ckpt_full), 0);
    ckpt_take = 1'b1;
    #1;
    check("t4_wrap_id", int'(ckpt_id), 0);
    step();
    idle();
    #1;
    check("t4_cnt4", int'(ckpt_full), 1);

    // 5: retire then rollback
    ret_en     = '1;
    ret_addr[0] = 0;
    ret_tag[0]  = 4;
    ret_addr[1] = 6;
    ret_tag[1]  = 10;
    wr(0, 0, 5);
    wr(1, 6, 50);
    rd_addr[0] = 0;
    rd_addr[2] = 6;
    rd_addr[3] = 0;
    #1;
    chk_rd("t5_x0_s0", 0, 0, 1);
    chk_rd("t5_x6_s1", 2, 6, 1);
    chk_rd("t5_x0_s1", 3, 0, 1);
    step();
    idle();
    rd_addr[0] = 6;
    #1;
    chk_rd("t5_x6_spec", 0, 50, 0);
    rollback    = 1'b1;
    ret_en[0]   = 1'b1;
    ret_addr[0] = 11;
    ret_tag[0]  = 30;
    wr(0, 6, 55);
    ckpt_take = 1'b1;
    step();
    idle();
    rd_addr[0] = 6;
    rd_addr[1] = 11;
    rd_addr[2] = 3;
    rd_addr[3] = 0;
    #1;
    chk_rd("t5_rb_x6", 0, 10, 1);
    chk_rd("t5_rb_x11", 1, 30, 1);
    chk_rd("t5_rb_x3", 2, 3, 1);
    chk_rd("t5_rb_x0", 3, 0, 1);
    check("t5_rb_empty", int'(ckpt_empty), 1);
    check("t5_rb_full", int'(ckpt_full), 0);
    check("t5_rb_id", int'(ckpt_id), 0);

    // 6: asynchronous reset during a restore
    ckpt_take = 1'b1;
    wr(0, 12, 33);
    step();
    idle();
    rd_addr[0] = 12;
    rd_addr[1] = 6;
    #1;
    chk_rd("t6_x12_pre", 0, 33, 0);
    ckpt_restore = 1'b1;
    ckpt_rs_id   = 0;
    #1;
    reset = 1'b0;
    #1;
    chk_rd("t6_x12", 0, 12, 1);
    chk_rd("t6_x6", 1, 6, 1);
    check("t6_empty", int'(ckpt_empty), 1);
    check("t6_full", int'(ckpt_full), 0);
    check("t6_id", int'(ckpt_id), 0);
    idle();
    @(negedge clock);
    reset = 1'b1;
    step();
    rollback = 1'b1;
    step();
    idle();
    rd_addr[0] = 6;
    rd_addr[1] = 11;
    #1;
    chk_rd("t6_rrat_x6", 0, 6, 1);
    chk_rd("t6_rrat_x11", 1, 11, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
